usb_dbg_tx_arbiter: RTL and testbench

USB_DBG_TX_ARBITER -- requirements
Module: usb_dbg_tx_arbiter

---
 rtl/usb_dbg_pkg.sv | 22 ++
 rtl/usb_dbg_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_usb_dbg_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_dbg_pkg.sv
// Shared encodings for the USB debug TX arbiter: FSM states, bus-owner codes
// and the bytes that terminate status and event frames.
package usb_dbg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      S_REQ,
      S_WAIT,
      S_REL,
      E_POP,
      TX_GO,
      TX_WAIT
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_STAT = 2'b01;
   localparam logic [1:0] OWN_EV   = 2'b10;

   localparam logic [7:0] STAT_EOF = 8'h0C;
   localparam logic [7:0] EV_EOF   = 8'h0A;

endpackage

// File: rtl/usb_dbg_tx_arbiter.sv
// Shares one UART transmitter between a periodic status source and an event
// source; a granted source keeps the UART for a whole frame, up to its EOF byte.
module usb_dbg_tx_arbiter #(
   parameter logic [23:0] STATUS_PERIOD = 24'd4800000,
   parameter logic [2:0]  DV_TIMEOUT    = 3'd4,
   parameter logic [7:0]  STAT_EOF      = usb_dbg_pkg::STAT_EOF,
   parameter logic [7:0]  EV_EOF        = usb_dbg_pkg::EV_EOF
) (
   input  logic       clk48,
   input  logic       rst,
   output logic       stat_inc,
   input  logic       stat_dv,
   input  logic [7:0] stat_q,
   input  logic       ev_valid,
   input  logic [7:0] ev_data,
   output logic       ev_ready,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic [1:0] owner,
   output logic [7:0] dv_timeouts
);
   import usb_dbg_pkg::*;

   localparam logic [23:0] PERIOD_LAST = STATUS_PERIOD - 24'd1;
   localparam logic [2:0]  WAIT_LAST   = DV_TIMEOUT - 3'd1;

   state_t      state;
   logic [23:0] period_cnt;
   logic        stat_due;
   logic        stat_again;
   logic [2:0]  wait_cnt;
   logic        tw_first;
   logic [1:0]  last_owner;
   logic        tx_start_q;

   logic period_hit;
   logic grant_stat;
   logic stat_tmo;
   logic tx_done;
   logic frame_end;
   logic stat_eof_done;

   assign period_hit    = (period_cnt == 24'd0);
   // Status wins a collision unless it was the last frame sent.
   assign grant_stat    = (state == IDLE) && stat_due && (!ev_valid || last_owner == OWN_EV);
   assign stat_tmo      = (state == S_WAIT) && !stat_dv && (wait_cnt == WAIT_LAST);
   assign tx_done       = (state == TX_WAIT) && !tw_first && !tx_busy;
   assign frame_end     = ((owner == OWN_STAT) && (tx_data == STAT_EOF)) ||
                          ((owner == OWN_EV)   && (tx_data == EV_EOF));
   assign stat_eof_done = tx_done && (owner == OWN_STAT) && (tx_data == STAT_EOF);

   // Period expiries during a status frame are remembered so that the next
   // frame follows instead of being swallowed by the frame-complete clear.
   always_ff @(posedge clk48) begin
      if (rst) begin
         period_cnt <= PERIOD_LAST;
         stat_due   <= 1'b0;
         stat_again <= 1'b0;
      end else begin
         period_cnt <= period_hit ? PERIOD_LAST : period_cnt - 24'd1;
         if (stat_tmo) begin
            stat_due   <= period_hit;
            stat_again <= 1'b0;
         end else if (stat_eof_done) begin
            stat_due   <= period_hit | stat_again;
            stat_again <= 1'b0;
         end else if (period_hit) begin
            stat_due <= 1'b1;
            if (owner == OWN_STAT || grant_stat)
               stat_again <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk48) begin
      if (rst) begin
         state       <= IDLE;
         stat_inc    <= 1'b0;
         ev_ready    <= 1'b0;
         tx_start_q  <= 1'b0;
         tx_data     <= 8'h00;
         owner       <= OWN_NONE;
         dv_timeouts <= 8'h00;
         wait_cnt    <= 3'd0;
         tw_first    <= 1'b0;
         last_owner  <= OWN_EV;
      end else begin
         tx_start_q <= 1'b0;
         ev_ready   <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_stat) begin
                  owner    <= OWN_STAT;
                  stat_inc <= 1'b1;
                  state    <= S_REQ;
               end else if (ev_valid) begin
                  owner <= OWN_EV;
                  state <= E_POP;
               end
            end
            S_REQ: begin
               wait_cnt <= 3'd0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (stat_dv) begin
                  tx_data  <= stat_q;
                  stat_inc <= 1'b0;
                  state    <= S_REL;
               end else if (stat_tmo) begin
                  stat_inc <= 1'b0;
                  owner    <= OWN_NONE;
                  if (dv_timeouts != 8'hFF)
                     dv_timeouts <= dv_timeouts + 8'd1;
                  state    <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            S_REL: state <= TX_GO;
            E_POP: begin
               tx_data  <= ev_data;
               ev_ready <= 1'b1;
               state    <= TX_GO;
            end
            TX_GO: begin
               if (!tx_busy) begin
                  tx_start_q <= 1'b1;
                  tw_first   <= 1'b1;
                  state      <= TX_WAIT;
               end
            end
            TX_WAIT: begin
               // tx_busy may lag tx_start by a cycle, so the first cycle is skipped.
               if (tw_first) begin
                  tw_first <= 1'b0;
               end else if (!tx_busy) begin
                  if (frame_end) begin
                     last_owner <= owner;
                     owner      <= OWN_NONE;
                     state      <= IDLE;
                  end else if (owner == OWN_STAT) begin
                     stat_inc <= 1'b1;
                     state    <= S_REQ;
                  end else if (ev_valid) begin
                     state <= E_POP;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A start pending from the previous edge must not escape while rst is high.
   assign tx_start = tx_start_q & ~rst;

endmodule

// File: tb/tb_usb_dbg_tx_arbiter.sv
// Scoreboard bench for usb_dbg_tx_arbiter with behavioural status, event and UART models.
module tb_usb_dbg_tx_arbiter;

   logic       clk48;
   logic       rst;
   logic       stat_inc;
   logic       stat_dv;
   logic [7:0] stat_q;
   logic       ev_valid;
   logic [7:0] ev_data;
   logic       ev_ready;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic [1:0] owner;
   logic [7:0] dv_timeouts;

   usb_dbg_tx_arbiter #(.STATUS_PERIOD(24'd16)) dut (
      .clk48(clk48), .rst(rst), .stat_inc(stat_inc), .stat_dv(stat_dv), .stat_q(stat_q),
      .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready), .tx_data(tx_data),
      .tx_start(tx_start), .tx_busy(tx_busy), .owner(owner), .dv_timeouts(dv_timeouts)
   );

   int checks = 0;
   int failures = 0;

   logic [7:0] stat_src[$];
   logic [7:0] ev_src[$];
   logic [7:0] exp_dat[$];
   logic [1:0] exp_own[$];
   logic [7:0] obs_dat[$];
   logic [1:0] obs_own[$];
   logic [1:0] own_trace[$];

   logic       ev_en = 1'b0;
   logic [1:0] prev_own = 2'b00;
   logic [7:0] held = 8'h00;
   logic       run_dv = 1'b0;
   int busy_cnt = 0;
   int run = 0;
   int last_run = 0;
   int tmo_cnt = 0;
   int inc_rises = 0;
   int inc_during_ev = 0;
   int hold_err = 0;
   int start_in_rst = 0;
   int cyc = 0;
   int ev_end_cyc = -1;
   int gap_cyc = -1;

   initial begin
      clk48 = 1'b0;
      forever #5 clk48 = ~clk48;
   end

   // Source/sink models and monitor, all on the falling edge.
   initial begin
      stat_dv = 1'b0; stat_q = 8'h00; ev_valid = 1'b0; ev_data = 8'h00; tx_busy = 1'b0;
      forever begin
         @(negedge clk48);
         cyc++;
         if (tx_start) begin
            if (rst) start_in_rst++;
            obs_dat.push_back(tx_data);
            obs_own.push_back(owner);
            held = tx_data;
            busy_cnt = 3;
            tx_busy = 1'b1;
         end else if (busy_cnt > 0) begin
            if (tx_data !== held) hold_err++;
            busy_cnt--;
            tx_busy = (busy_cnt != 0);
         end
         if (rst) begin
            busy_cnt = 0; tx_busy = 1'b0; run = 0; run_dv = 1'b0;
         end
         if (prev_own == 2'b10 && owner !== 2'b10) ev_end_cyc = cyc;
         if (owner !== prev_own) begin
            own_trace.push_back(owner);
            prev_own = owner;
         end
         if (stat_inc) begin
            if (owner == 2'b10) inc_during_ev++;
            if (run == 0) begin
               inc_rises++;
               if (ev_end_cyc >= 0 && gap_cyc < 0) gap_cyc = cyc - ev_end_cyc;
            end
            run++;
         end else if (run > 0) begin
            last_run = run;
            if (!run_dv) tmo_cnt++;
            run = 0;
            run_dv = 1'b0;
         end
         // Status source answers on the second cycle it sees stat_inc high.
         stat_dv = 1'b0;
         if (stat_inc && run == 2 && stat_src.size() > 0) begin
            stat_dv = 1'b1;
            stat_q = stat_src.pop_front();
            run_dv = 1'b1;
         end
         if (ev_ready && ev_src.size() > 0) void'(ev_src.pop_front());
         ev_valid = ev_en && (ev_src.size() > 0);
         ev_data = ev_valid ? ev_src[0] : 8'h00;
      end
   end

   task automatic exp_stat(input logic [7:0] b);
      stat_src.push_back(b);
      exp_dat.push_back(b);
      exp_own.push_back(2'b01);
   endtask

   task automatic exp_ev(input logic [7:0] b);
      ev_src.push_back(b);
      exp_dat.push_back(b);
      exp_own.push_back(2'b10);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ev_en = 1'b0;
      repeat (2) @(negedge clk48);
      #1;
      stat_src.delete(); ev_src.delete(); exp_dat.delete(); exp_own.delete();
      obs_dat.delete(); obs_own.delete(); own_trace.delete();
      inc_rises = 0; inc_during_ev = 0; tmo_cnt = 0; last_run = 0; hold_err = 0;
      start_in_rst = 0; ev_end_cyc = -1; gap_cyc = -1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (stat_inc !== 1'b0) begin failures++; $display("FAIL reset_stat_inc got=%b want=0", stat_inc); end
      checks++; if (ev_ready !== 1'b0) begin failures++; $display("FAIL reset_ev_ready got=%b want=0", ev_ready); end
      checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
      checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
      checks++; if (owner !== 2'b00) begin failures++; $display("FAIL reset_owner got=%b want=00", owner); end
      checks++; if (dv_timeouts !== 8'h00) begin failures++; $display("FAIL reset_dv_timeouts got=%h want=00", dv_timeouts); end
   endtask

   task automatic test_status_frame();
      do_reset();
      exp_stat(8'h41); exp_stat(8'h42); exp_stat(8'h0C);
      for (int i = 0; i < 300 && obs_dat.size() < 3; i++) begin @(negedge clk48); #1; end
      checks++; if (obs_dat.size() < 3) begin failures++; $display("FAIL stat_timeout got=%0d want=3 bytes", obs_dat.size()); end
      // One rise per byte proves stat_inc dropped between bytes.
      checks++; if (inc_rises != 3) begin failures++; $display("FAIL stat_inc_rises got=%0d want=3", inc_rises); end
      while (exp_dat.size() > 0 && obs_dat.size() > 0) begin
         logic [7:0] ed;
         logic [1:0] eo;
         ed = exp_dat.pop_front(); eo = exp_own.pop_front();
         checks++; if (obs_dat[0] !== ed) begin failures++; $display("FAIL stat_byte got=%h want=%h", obs_dat[0], ed); end
         checks++; if (obs_own[0] !== eo) begin failures++; $display("FAIL stat_owner got=%b want=%b", obs_own[0], eo); end
         void'(obs_dat.pop_front()); void'(obs_own.pop_front());
      end
      repeat (6) begin @(negedge clk48); #1; end
      checks++; if (own_trace.size() < 2 || own_trace[0] !== 2'b01 || own_trace[1] !== 2'b00) begin
         failures++; $display("FAIL stat_owner_trace got=%p want=01,00,...", own_trace);
      end
      checks++; if (hold_err != 0) begin failures++; $display("FAIL stat_tx_hold got=%0d want=0", hold_err); end
   endtask

   task automatic test_round_robin();
      do_reset();
      exp_stat(8'h41); exp_stat(8'h42); exp_stat(8'h0C);
      exp_ev(8'h78); exp_ev(8'h0A);
      exp_stat(8'h43); exp_stat(8'h44); exp_stat(8'h0C);
      // Event becomes valid in the same cycle stat_due first rises.
      repeat (16) @(posedge clk48);
      #1 ev_en = 1'b1;
      for (int i = 0; i < 600 && obs_dat.size() < 8; i++) begin @(negedge clk48); #1; end
      checks++; if (obs_dat.size() < 8) begin failures++; $display("FAIL rr_timeout got=%0d want=8 bytes", obs_dat.size()); end
      while (exp_dat.size() > 0 && obs_dat.size() > 0) begin
         logic [7:0] ed;
         logic [1:0] eo;
         ed = exp_dat.pop_front(); eo = exp_own.pop_front();
         checks++; if (obs_dat[0] !== ed) begin failures++; $display("FAIL rr_byte got=%h want=%h", obs_dat[0], ed); end
         checks++; if (obs_own[0] !== eo) begin failures++; $display("FAIL rr_owner got=%b want=%b", obs_own[0], eo); end
         void'(obs_dat.pop_front()); void'(obs_own.pop_front());
      end
      checks++; if (inc_during_ev != 0) begin failures++; $display("FAIL rr_inc_in_ev got=%0d want=0", inc_during_ev); end
      checks++; if (hold_err != 0) begin failures++; $display("FAIL rr_tx_hold got=%0d want=0", hold_err); end
   endtask

   task automatic test_ev_lock();
      do_reset();
      ev_en = 1'b1;
      exp_ev(8'h68); exp_ev(8'h65); exp_ev(8'h79); exp_ev(8'h0A);
      exp_stat(8'h5A); exp_stat(8'h0C);
      for (int i = 0; i < 400 && obs_dat.size() < 6; i++) begin @(negedge clk48); #1; end
      checks++; if (obs_dat.size() < 6) begin failures++; $display("FAIL lock_timeout got=%0d want=6 bytes", obs_dat.size()); end
      while (exp_dat.size() > 0 && obs_dat.size() > 0) begin
         logic [7:0] ed;
         logic [1:0] eo;
         ed = exp_dat.pop_front(); eo = exp_own.pop_front();
         checks++; if (obs_dat[0] !== ed) begin failures++; $display("FAIL lock_byte got=%h want=%h", obs_dat[0], ed); end
         checks++; if (obs_own[0] !== eo) begin failures++; $display("FAIL lock_owner got=%b want=%b", obs_own[0], eo); end
         void'(obs_dat.pop_front()); void'(obs_own.pop_front());
      end
      checks++; if (inc_during_ev != 0) begin failures++; $display("FAIL lock_inc_in_ev got=%0d want=0", inc_during_ev); end
      checks++; if (gap_cyc < 1 || gap_cyc > 3) begin failures++; $display("FAIL lock_stat_gap got=%0d want=1..3", gap_cyc); end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 0; i < 200 && tmo_cnt < 1; i++) begin @(negedge clk48); #1; end
      checks++; if (dv_timeouts !== 8'h01) begin failures++; $display("FAIL tmo_count got=%h want=01", dv_timeouts); end
      // One S_REQ cycle plus DV_TIMEOUT cycles in S_WAIT.
      checks++; if (last_run != 5) begin failures++; $display("FAIL tmo_inc_len got=%0d want=5", last_run); end
      checks++; if (owner !== 2'b00) begin failures++; $display("FAIL tmo_owner got=%b want=00", owner); end
      checks++; if (obs_dat.size() != 0) begin failures++; $display("FAIL tmo_no_tx got=%0d want=0", obs_dat.size()); end
   endtask

   task automatic test_rst_mid();
      do_reset();
      stat_src.push_back(8'h41); stat_src.push_back(8'h42);
      stat_src.push_back(8'h43); stat_src.push_back(8'h0C);
      for (int i = 0; i < 300 && obs_dat.size() < 2; i++) begin @(negedge clk48); #1; end
      checks++; if (obs_dat.size() < 2) begin failures++; $display("FAIL rstmid_timeout got=%0d want=2 bytes", obs_dat.size()); end
      @(negedge clk48);
      #1 rst = 1'b1;
      @(negedge clk48);
      #1;
      checks++; if (stat_inc !== 1'b0) begin failures++; $display("FAIL rstmid_stat_inc got=%b want=0", stat_inc); end
      checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL rstmid_tx_start got=%b want=0", tx_start); end
      checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rstmid_tx_data got=%h want=00", tx_data); end
      checks++; if (owner !== 2'b00) begin failures++; $display("FAIL rstmid_owner got=%b want=00", owner); end
      checks++; if (ev_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ev_ready got=%b want=0", ev_ready); end
      checks++; if (dv_timeouts !== 8'h00) begin failures++; $display("FAIL rstmid_dv_timeouts got=%h want=00", dv_timeouts); end
      checks++; if (start_in_rst != 0) begin failures++; $display("FAIL rstmid_start_in_rst got=%0d want=0", start_in_rst); end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 1000 && tmo_cnt < 10; i++) begin @(negedge clk48); #1; end
      checks++; if (dv_timeouts !== 8'd10) begin failures++; $display("FAIL sat_mid got=%0d want=10", dv_timeouts); end
      for (int i = 0; i < 8000 && tmo_cnt < 300; i++) begin @(negedge clk48); #1; end
      checks++; if (tmo_cnt < 300) begin failures++; $display("FAIL sat_timeout got=%0d want=300 timeouts", tmo_cnt); end
      checks++; if (dv_timeouts !== 8'hFF) begin failures++; $display("FAIL sat_hold got=%h want=ff", dv_timeouts); end
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_status_frame();
      test_round_robin();
      test_ev_lock();
      test_timeout();
      test_rst_mid();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
